// File: rtl/sram_frame_reader.sv
// rtl/sram_frame_reader.sv - streams a frame of SRAM words through a 2-deep FIFO; game-logic writes take priority
module sram_frame_reader #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int FRAME_WORDS   = 40320
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  input  logic                     wr_req,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ack,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic                     enable,
  output logic [DATA_WIDTH-1:0]    sram_in,
  input  logic [DATA_WIDTH-1:0]    sram_out
);

  // Counters need one extra bit so a full 2^ADDRESS_WIDTH frame is representable.
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]            issued;
  logic [CW-1:0]            consumed;
  logic [CW-1:0]            issued_inc;
  logic [CW-1:0]            consumed_inc;
  logic                     inflight;
  logic [DATA_WIDTH-1:0]    fifo_mem [2];
  logic                     fifo_head;
  logic                     fifo_tail;
  logic [1:0]               fifo_count;
  logic                     pop;
  logic [2:0]               occupancy;
  logic                     rd_room;
  logic                     issue_rd;
  logic                     take_start;

  assign issued_inc   = issued + CW'(1);
  assign consumed_inc = consumed + CW'(1);
  assign pix_valid    = (fifo_count != 2'd0);
  assign pix_data     = fifo_mem[fifo_head];
  assign pop          = pix_valid & pix_ready;
  assign fifo_tail    = fifo_head ^ fifo_count[0];
  assign busy         = (state == S_READ) || (state == S_DRAIN);
  assign done         = (state == S_DONE);

  // Credit the word leaving this cycle so a steady stream sustains one read per cycle.
  assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign rd_room   = (occupancy < 3'd2);

  always_comb begin
    wr_ack   = 1'b0;
    enable   = 1'b0;
    address  = rd_ptr;
    sram_in  = wr_data;
    issue_rd = 1'b0;
    if (wr_req) begin
      wr_ack  = 1'b1;
      enable  = 1'b1;
      address = wr_addr;
    end else if ((state == S_READ) && rd_room) begin
      issue_rd = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    take_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          state_nxt  = S_READ;
        end
      end
      S_READ: begin
        if (issue_rd && (issued_inc == FRAME_LAST)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && (consumed_inc == FRAME_LAST)) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      issued     <= '0;
      consumed   <= '0;
      inflight   <= 1'b0;
      fifo_head  <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      state    <= state_nxt;
      inflight <= issue_rd;
      if (take_start) begin
        rd_ptr   <= base_addr;
        issued   <= '0;
        consumed <= '0;
      end else begin
        if (issue_rd) begin
          rd_ptr <= rd_ptr + ADDRESS_WIDTH'(1);
          issued <= issued_inc;
        end
        if (pop) consumed <= consumed_inc;
      end
      fifo_head  <= fifo_head ^ pop;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // Read data returns the cycle after issue; when full, the slot being popped is reused.
  always_ff @(posedge CLK) begin
    if (!RST && inflight) fifo_mem[fifo_tail] <= sram_out;
  end

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb/tb_sram_frame_reader.sv - directed checks of sram_frame_reader against SRAM models
module tb_sram_frame_reader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        start_a = 1'b0, pix_ready_a = 1'b1, wr_req_a = 1'b0;
  logic [15:0] base_a = '0, wr_addr_a = '0, address_a;
  logic [7:0]  wr_data_a = '0, pix_data_a, sram_in_a, sram_out_a = '0;
  logic        busy_a, done_a, pix_valid_a, wr_ack_a, enable_a;

  logic        start_b = 1'b0, pix_ready_b = 1'b1, wr_req_b = 1'b0;
  logic [15:0] base_b = '0, wr_addr_b = '0, address_b;
  logic [7:0]  wr_data_b = '0, pix_data_b, sram_in_b, sram_out_b = '0;
  logic        busy_b, done_b, pix_valid_b, wr_ack_b, enable_b;

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_b [0:65535];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] got[$];
  int first_pop, last_pop, done_cyc;
  bit en_bad, fifo_bad, busy_at_done_bad;

  always #5 CLK = ~CLK;

  sram_frame_reader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .FRAME_WORDS(4)) u_a (
    .CLK(CLK), .RST(RST), .start(start_a), .base_addr(base_a),
    .busy(busy_a), .done(done_a), .pix_data(pix_data_a), .pix_valid(pix_valid_a),
    .pix_ready(pix_ready_a), .wr_req(wr_req_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .wr_ack(wr_ack_a), .address(address_a), .enable(enable_a), .sram_in(sram_in_a),
    .sram_out(sram_out_a)
  );

  sram_frame_reader #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8), .FRAME_WORDS(3)) u_b (
    .CLK(CLK), .RST(RST), .start(start_b), .base_addr(base_b),
    .busy(busy_b), .done(done_b), .pix_data(pix_data_b), .pix_valid(pix_valid_b),
    .pix_ready(pix_ready_b), .wr_req(wr_req_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_ack(wr_ack_b), .address(address_b), .enable(enable_b), .sram_in(sram_in_b),
    .sram_out(sram_out_b)
  );

  always @(posedge CLK) begin
    if (enable_a) mem_a[address_a] <= sram_in_a;
    else          sram_out_a <= mem_a[address_a];
    if (enable_b) mem_b[address_b] <= sram_in_b;
    else          sram_out_b <= mem_b[address_b];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame_a(input logic [15:0] base);
    start_a = 1'b1;
    base_a  = base;
    tick();
    start_a = 1'b0;
  endtask

  // mode 0: pix_ready held high; mode 1: pix_ready pattern 1,0,0,1 repeating
  task automatic collect_a(input int mode, input int wr_cycle, input int restart_cycle,
                           input int stop_pops);
    got.delete();
    first_pop = -1; last_pop = -1; done_cyc = -1;
    en_bad = 0; fifo_bad = 0; busy_at_done_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      pix_ready_a = (mode == 0) ? 1'b1 : (((i - 1) % 4 == 0) || ((i - 1) % 4 == 3));
      wr_req_a    = (i == wr_cycle);
      wr_addr_a   = 16'h0102;
      wr_data_a   = 8'hAA;
      start_a     = (i == restart_cycle);
      base_a      = (i == restart_cycle) ? 16'h0300 : base_a;
      #1;
      if (i == wr_cycle) begin
        check("wr_ack", 32'(wr_ack_a), 32'd1);
        check("wr_enable", 32'(enable_a), 32'd1);
        check("wr_address", 32'(address_a), 32'h0102);
      end else if (enable_a) en_bad = 1;
      if (u_a.fifo_count > 2'd2) fifo_bad = 1;
      if (pix_valid_a && pix_ready_a) begin
        got.push_back(pix_data_a);
        if (first_pop < 0) first_pop = i;
        last_pop = i;
      end
      if (done_a) begin
        done_cyc = i;
        if (busy_a) busy_at_done_bad = 1;
        break;
      end
      if (stop_pops > 0 && got.size() == stop_pops) break;
      tick();
    end
    wr_req_a = 1'b0;
    start_a  = 1'b0;
  endtask

  task automatic check_words(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] exp_w [4];
    exp_w[0] = w0; exp_w[1] = w1; exp_w[2] = w2; exp_w[3] = w3;
    check({tag, "_count"}, 32'(got.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      check($sformatf("%s_w%0d", tag, k), (k < got.size()) ? 32'(got[k]) : 32'hFFFF_FFFF,
            32'(exp_w[k]));
  endtask

  task automatic preload_a(input logic [15:0] base, input logic [7:0] first);
    for (int k = 0; k < 4; k++) mem_a[16'(32'(base) + k)] = 8'(32'(first) + k);
  endtask

  initial begin
    preload_a(16'h0100, 8'h10);
    preload_a(16'h0200, 8'h20);
    preload_a(16'h0300, 8'h30);
    mem_b[16'hFFFF] = 8'h71;
    mem_b[16'h0000] = 8'h72;
    mem_b[16'h0001] = 8'h73;

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_pix_valid", 32'(pix_valid_a), 32'd0);
    check("rst_wr_ack", 32'(wr_ack_a), 32'd0);
    check("rst_enable", 32'(enable_a), 32'd0);
    check("rst_pix_valid_b", 32'(pix_valid_b), 32'd0);

    // basic read, started in the first cycle after reset release
    start_frame_a(16'h0100);
    check("basic_busy", 32'(busy_a), 32'd1);
    collect_a(0, 0, 0, 0);
    check_words("basic", 8'h10, 8'h11, 8'h12, 8'h13);
    check("basic_first_pop", 32'(first_pop), 32'd3);
    check("basic_last_pop", 32'(last_pop), 32'd6);
    check("basic_done_cyc", 32'(done_cyc), 32'd7);
    check("basic_no_write", 32'(en_bad), 32'd0);
    check("basic_busy_at_done", 32'(busy_at_done_bad), 32'd0);
    tick();
    check("basic_done_pulse", 32'(done_a), 32'd0);

    // backpressure
    start_frame_a(16'h0100);
    collect_a(1, 0, 0, 0);
    check_words("bp", 8'h10, 8'h11, 8'h12, 8'h13);
    check("bp_last_pop", 32'(last_pop), 32'd9);
    check("bp_done_cyc", 32'(done_cyc), 32'd10);
    check("bp_no_write", 32'(en_bad), 32'd0);
    check("bp_fifo_bound", 32'(fifo_bad), 32'd0);
    tick();

    // write priority in the first issue slot: 0x0102 is overwritten before it is read
    start_frame_a(16'h0100);
    collect_a(0, 1, 0, 0);
    check_words("wr", 8'h10, 8'h11, 8'hAA, 8'h13);
    check("wr_first_pop", 32'(first_pop), 32'd4);
    check("wr_done_cyc", 32'(done_cyc), 32'd8);
    check("wr_mem", 32'(mem_a[16'h0102]), 32'h00AA);
    mem_a[16'h0102] = 8'h12;
    tick();

    // write accepted while idle
    wr_req_a = 1'b1; wr_addr_a = 16'h0400; wr_data_a = 8'h5C;
    #1;
    check("idle_wr_ack", 32'(wr_ack_a), 32'd1);
    tick();
    wr_req_a = 1'b0;
    #1;
    check("idle_wr_mem", 32'(mem_a[16'h0400]), 32'h005C);
    check("idle_wr_ack_low", 32'(wr_ack_a), 32'd0);

    // start while busy is ignored
    start_frame_a(16'h0100);
    collect_a(0, 0, 2, 0);
    check_words("ign", 8'h10, 8'h11, 8'h12, 8'h13);
    check("ign_done_cyc", 32'(done_cyc), 32'd7);
    tick();

    // address wrap on the 3-word instance
    start_b = 1'b1; base_b = 16'hFFFF;
    tick();
    start_b = 1'b0;
    check("wrap_addr0", 32'(address_b), 32'hFFFF);
    tick();
    check("wrap_addr1", 32'(address_b), 32'h0000);
    tick();
    check("wrap_addr2", 32'(address_b), 32'h0001);
    check("wrap_w0", {pix_valid_b, 23'd0, pix_data_b}, {1'b1, 23'd0, 8'h71});
    tick();
    check("wrap_w1", {pix_valid_b, 23'd0, pix_data_b}, {1'b1, 23'd0, 8'h72});
    tick();
    check("wrap_w2", {pix_valid_b, 23'd0, pix_data_b}, {1'b1, 23'd0, 8'h73});
    tick();
    check("wrap_done", 32'(done_b), 32'd1);
    tick();

    // reset mid-frame after two pops, then restart from a new base
    start_frame_a(16'h0100);
    collect_a(0, 0, 0, 2);
    check("mid_pops", 32'(got.size()), 32'd2);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_outs", {28'd0, busy_a, done_a, pix_valid_a, wr_ack_a}, 32'd0);
    check("mid_rst_enable", 32'(enable_a), 32'd0);
    check("mid_rst_addr", 32'(address_a), 32'd0);
    start_frame_a(16'h0200);
    collect_a(0, 0, 0, 0);
    check_words("mid_new", 8'h20, 8'h21, 8'h22, 8'h23);
    check("mid_first_pop", 32'(first_pop), 32'd3);
    check("mid_done_cyc", 32'(done_cyc), 32'd7);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
